// File: rtl/scan_chain_responder.sv
// CUT-side scan responder: shift chain, rotate/XOR response capture, load-length checking and pattern counters.
// Optional capture-bit forcing is compiled in when SCAN_FAULT_INJECT_EN is defined.
module scan_chain_responder #(
  parameter int                  SCAN_LEN  = 16,
  parameter logic [SCAN_LEN-1:0] RESP_XOR  = 16'hA5A5,
  parameter int                  FAULT_BIT = 0,
  parameter logic                FAULT_VAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cut_scanmode,
  input  logic        cut_sdi,
  input  logic        fault_en,
  output logic        cut_sdo,
  output logic [15:0] pattern_count,
  output logic [15:0] capture_count,
  output logic        load_error
);

  // Wide enough to hold the saturation value SCAN_LEN+1.
  localparam int CNT_W = $clog2(SCAN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SCAN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SCAN_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SCAN_LEN-1:0] chain;
  logic [SCAN_LEN-1:0] resp;
  logic [SCAN_LEN-1:0] capture_val;
  logic [CNT_W-1:0]    shift_cnt;
  logic                do_shift;
  logic                do_capture;
  logic                first_shift;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cut_scanmode) state_nxt = S_SHIFT;
      S_SHIFT:   if (!cut_scanmode) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = cut_scanmode ? S_SHIFT : S_HOLD;
      S_HOLD:    if (cut_scanmode) state_nxt = S_SHIFT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Shifting is legal from any state; only the first low edge after a shift run captures.
  always_comb begin
    do_shift    = cut_scanmode;
    do_capture  = 1'b0;
    first_shift = 1'b1;
    if (state == S_SHIFT) begin
      do_capture  = !cut_scanmode;
      first_shift = 1'b0;
    end
  end

  assign resp = chain ^ {chain[0], chain[SCAN_LEN-1:1]} ^ RESP_XOR;

`ifdef SCAN_FAULT_INJECT_EN
  always_comb begin
    capture_val = resp;
    if (fault_en) capture_val[FAULT_BIT] = FAULT_VAL;
  end
`else
  assign capture_val = resp;

  // Fault controls are accepted but have no function in this build.
  logic fault_en_unused;
  assign fault_en_unused = fault_en;
  localparam int fault_cfg_unused = FAULT_BIT + int'(FAULT_VAL);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain         <= '0;
      shift_cnt     <= '0;
      pattern_count <= '0;
      capture_count <= '0;
      load_error    <= 1'b0;
    end else if (do_shift) begin
      chain <= {chain[SCAN_LEN-2:0], cut_sdi};
      if (first_shift)             shift_cnt <= CNT_W'(1);
      else if (shift_cnt != CNT_SAT) shift_cnt <= shift_cnt + CNT_W'(1);
    end else if (do_capture) begin
      chain         <= capture_val;
      capture_count <= capture_count + 16'd1;
      if (shift_cnt == CNT_FULL) pattern_count <= pattern_count + 16'd1;
      else                       load_error    <= 1'b1;
      shift_cnt     <= '0;
    end
  end

  assign cut_sdo = chain[SCAN_LEN-1];

endmodule

// File: tb/tb_scan_chain_responder.sv
// Self-checking bench for scan_chain_responder: vector table, directed corner sequences and a randomized
// run compared against an input-history reference model.
module tb_scan_chain_responder;

  localparam int L = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cut_scanmode = 1'b0;
  logic        cut_sdi = 1'b0;
  logic        fault_en = 1'b0;
  logic        cut_sdo;
  logic [15:0] pattern_count;
  logic [15:0] capture_count;
  logic        load_error;

  scan_chain_responder #(
    .SCAN_LEN (L),
    .RESP_XOR (16'hA5A5),
    .FAULT_BIT(0),
    .FAULT_VAL(1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cut_scanmode (cut_scanmode),
    .cut_sdi      (cut_sdi),
    .fault_en     (fault_en),
    .cut_sdo      (cut_sdo),
    .pattern_count(pattern_count),
    .capture_count(capture_count),
    .load_error   (load_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_model = 1'b0;

  // Reference model: a capture is the first low scanmode edge after a high one; the load
  // length is the number of consecutive high edges before it.
  logic [15:0] m_chain;
  logic        m_prev_sm;
  int          m_run;
  logic [15:0] m_pat;
  logic [15:0] m_cap;
  logic        m_err;

  typedef struct {
    logic [15:0] load;
    logic [15:0] unload;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic sm, input logic sdi, input logic fe);
    logic [15:0] rot;
    logic [15:0] resp;
    if (!r) begin
      m_chain = '0; m_prev_sm = 1'b0; m_run = 0; m_pat = '0; m_cap = '0; m_err = 1'b0;
    end else if (sm) begin
      m_chain   = {m_chain[14:0], sdi};
      m_run     = m_run + 1;
      m_prev_sm = 1'b1;
    end else begin
      if (m_prev_sm) begin
        rot  = (m_chain >> 1) | (m_chain << 15);
        resp = m_chain ^ rot ^ 16'hA5A5;
`ifdef SCAN_FAULT_INJECT_EN
        if (fe) resp[0] = 1'b0;
`else
        if (fe) resp = resp;
`endif
        m_chain = resp;
        m_cap   = m_cap + 16'd1;
        if (m_run == L) m_pat = m_pat + 16'd1;
        else            m_err = 1'b1;
        m_run = 0;
      end
      m_prev_sm = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic sm, input logic sdi, input logic fe);
    rst = r; cut_scanmode = sm; cut_sdi = sdi; fault_en = fe;
    @(posedge clk);
    #1;
    model_edge(r, sm, sdi, fe);
    if (chk_model) begin
      check("rand_sdo", 32'(cut_sdo), 32'(m_chain[15]));
      check("rand_pattern_count", 32'(pattern_count), 32'(m_pat));
      check("rand_capture_count", 32'(capture_count), 32'(m_cap));
      check("rand_load_error", 32'(load_error), 32'(m_err));
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic capture(input logic fe);
    step(1'b1, 1'b0, 1'b0, fe);
  endtask

  // Shifts w in MSB first while collecting the outgoing stream MSB first.
  task automatic shift_word(input logic [15:0] w, output logic [15:0] got);
    for (int b = L - 1; b >= 0; b--) begin
      got[b] = cut_sdo;
      step(1'b1, 1'b1, w[b], 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] got;
    logic [15:0] fault_exp;
    int cycles;
    int hi;
    int lo;

    vecs[0] = '{16'h0000, 16'hA5A5};
    vecs[1] = '{16'h0001, 16'h25A4};
    vecs[2] = '{16'hFFFF, 16'hA5A5};
    vecs[3] = '{16'h8000, 16'h65A5};
    vecs[4] = '{16'h1234, 16'hBE8B};

    // Reset state, and IDLE ignores a low scanmode.
    do_reset();
    check("reset_sdo", 32'(cut_sdo), 32'd0);
    check("reset_pattern_count", 32'(pattern_count), 32'd0);
    check("reset_capture_count", 32'(capture_count), 32'd0);
    check("reset_load_error", 32'(load_error), 32'd0);
    repeat (3) capture(1'b0);
    check("idle_no_capture", 32'(capture_count), 32'd0);

    // Vector table: each load unloads the previous pattern's response.
    for (int i = 0; i < 5; i++) begin
      shift_word(vecs[i].load, got);
      if (i > 0) check("table_unload", 32'(got), 32'(vecs[i-1].unload));
      capture(1'b0);
      if (i == 0) begin
        check("first_sdo_after_capture", 32'(cut_sdo), 32'(vecs[0].unload[15]));
        check("first_pattern_count", 32'(pattern_count), 32'd1);
        check("first_capture_count", 32'(capture_count), 32'd1);
      end
    end
    shift_word(16'h0000, got);
    check("table_unload_last", 32'(got), 32'(vecs[4].unload));
    check("table_pattern_count", 32'(pattern_count), 32'd5);
    check("table_capture_count", 32'(capture_count), 32'd5);
    check("table_load_error", 32'(load_error), 32'd0);

    // Short load sets the sticky error; a correct pattern afterwards does not clear it.
    do_reset();
    repeat (15) step(1'b1, 1'b1, 1'b0, 1'b0);
    capture(1'b0);
    check("short_load_error", 32'(load_error), 32'd1);
    check("short_pattern_count", 32'(pattern_count), 32'd0);
    check("short_capture_count", 32'(capture_count), 32'd1);
    shift_word(16'h0000, got);
    capture(1'b0);
    check("sticky_load_error", 32'(load_error), 32'd1);
    check("sticky_pattern_count", 32'(pattern_count), 32'd1);
    check("sticky_capture_count", 32'(capture_count), 32'd2);

    // Overlong loads: one extra bit, and a run long enough to expose a wrapping shift counter.
    do_reset();
    repeat (17) step(1'b1, 1'b1, 1'b0, 1'b0);
    capture(1'b0);
    check("long17_load_error", 32'(load_error), 32'd1);
    check("long17_pattern_count", 32'(pattern_count), 32'd0);
    do_reset();
    repeat (48) step(1'b1, 1'b1, 1'b0, 1'b0);
    capture(1'b0);
    check("long48_load_error", 32'(load_error), 32'd1);
    check("long48_pattern_count", 32'(pattern_count), 32'd0);

    // A five-cycle low pulse is one capture and the captured chain stays frozen.
    do_reset();
    shift_word(16'h0000, got);
    repeat (5) capture(1'b0);
    check("hold_capture_count", 32'(capture_count), 32'd1);
    shift_word(16'h0000, got);
    check("hold_unload", 32'(got), 32'hA5A5);

    // Reset in the middle of a load.
    do_reset();
    shift_word(16'h0000, got);
    capture(1'b0);
    repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0);
    check("midshift_sdo_before_reset", 32'(cut_sdo), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("midshift_reset_sdo", 32'(cut_sdo), 32'd0);
    check("midshift_reset_capture_count", 32'(capture_count), 32'd0);
    check("midshift_reset_pattern_count", 32'(pattern_count), 32'd0);
    capture(1'b0);
    check("midshift_reset_idle", 32'(capture_count), 32'd0);
    shift_word(16'h0000, got);
    capture(1'b0);
    shift_word(16'h0000, got);
    check("midshift_reload_unload", 32'(got), 32'hA5A5);
    check("midshift_reload_pattern_count", 32'(pattern_count), 32'd1);

    // Fault request on the capture edge.
`ifdef SCAN_FAULT_INJECT_EN
    fault_exp = 16'hA5A4;
`else
    fault_exp = 16'hA5A5;
`endif
    do_reset();
    shift_word(16'h0000, got);
    capture(1'b1);
    shift_word(16'h0000, got);
    check("fault_unload", 32'(got), 32'(fault_exp));
    check("fault_pattern_count", 32'(pattern_count), 32'd1);

    // Randomized runs against the reference model, with occasional resets.
    do_reset();
    chk_model = 1'b1;
    cycles = 0;
    while (cycles < 3000) begin
      hi = ($urandom_range(0, 9) < 6) ? L : int'($urandom_range(1, 20));
      lo = int'($urandom_range(1, 3));
      for (int k = 0; k < hi; k++)
        step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, 1'b1, 1'($urandom), 1'($urandom));
      for (int k = 0; k < lo; k++)
        step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, 1'b0, 1'($urandom), 1'($urandom));
      cycles += hi + lo;
    end
    chk_model = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
